timer_sequencer: RTL and testbench



---
 rtl/timer_pkg.sv | 16 +
 rtl/tff_counter_core.sv | 31 +++
 rtl/timer_sequencer.sv | 110 +++++++++++
 tb/tb_timer_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the timer sequencer and its counter core.
package timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_PRESCALE_W = 4;

endpackage

// File: rtl/tff_counter_core.sv
// Synchronous T-flip-flop up-counter: bit i toggles when EN is high and all lower bits are one.
module tff_counter_core #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             CLR,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] t;

    assign t[0] = EN;

    // Each toggle enable is the tick ANDed with every lower counter bit.
    for (genvar i = 1; i < WIDTH; i++) begin : g_toggle
        assign t[i] = EN & (&Q[i-1:0]);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q <= '0;
        end else if (CLR) begin
            Q <= '0;
        end else begin
            Q <= Q ^ t;
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// Timer controller: latches period/prescale/mode on START and gates the T-FF counter with a prescaler tick.
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic                  STOP,
    input  logic                  MODE,
    input  logic [WIDTH-1:0]      PERIOD,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic [WIDTH-1:0]      Q,
    output logic                  BUSY,
    output logic                  TC,
    output logic                  DONE
);

    state_t                state;
    logic [WIDTH-1:0]      periodL;
    logic [PRESCALE_W-1:0] prescaleL;
    logic [PRESCALE_W-1:0] prescaler;
    logic                  modeL;

    logic accept;
    logic tick;
    logic atTerm;
    logic cntEn;
    logic cntClr;

    assign accept = (state != S_RUN) && START && !STOP;
    assign tick   = (state == S_RUN) && (prescaler == prescaleL);
    assign atTerm = (Q == periodL);

    // STOP outranks a tick, so the counter only advances on an unstopped tick below terminal count.
    assign cntEn  = (state == S_RUN) && !STOP && tick && !atTerm;
    assign cntClr = accept
                 || ((state == S_DONE) && STOP)
                 || ((state == S_RUN) && STOP)
                 || ((state == S_RUN) && !STOP && tick && atTerm && (modeL == MODE_PERIODIC));

    tff_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .CLK  (CLK),
        .RST_N(RST_N),
        .EN   (cntEn),
        .CLR  (cntClr),
        .Q    (Q)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            periodL   <= '0;
            prescaleL <= '0;
            prescaler <= '0;
            modeL     <= MODE_ONESHOT;
            BUSY      <= 1'b0;
            TC        <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            TC <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state     <= S_RUN;
                        periodL   <= PERIOD;
                        prescaleL <= PRESCALE;
                        modeL     <= MODE;
                        prescaler <= '0;
                        BUSY      <= 1'b1;
                        DONE      <= 1'b0;
                    end else if ((state == S_DONE) && STOP) begin
                        state <= S_IDLE;
                        DONE  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (STOP) begin
                        state     <= S_IDLE;
                        prescaler <= '0;
                        BUSY      <= 1'b0;
                    end else if (tick) begin
                        prescaler <= '0;
                        if (atTerm) begin
                            TC <= 1'b1;
                            if (modeL == MODE_ONESHOT) begin
                                state <= S_DONE;
                                BUSY  <= 1'b0;
                                DONE  <= 1'b1;
                            end
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    prescaler <= '0;
                    BUSY      <= 1'b0;
                    DONE      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer against an elapsed-cycle arithmetic model.
module tb_timer_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] period;
    logic [3:0] prescale;
    logic [7:0] q;
    logic       busy;
    logic       tc;
    logic       done;

    int errors = 0;
    int checks = 0;

    // Reference model: elapsed cycles since the START edge determine everything.
    logic [7:0] mQ;
    logic       mBusy;
    logic       mTc;
    logic       mDone;
    longint     n;
    int         lPer;
    int         lPre;
    logic       lMode;

    timer_sequencer #(
        .WIDTH     (8),
        .PRESCALE_W(4)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .START   (start),
        .STOP    (stop),
        .MODE    (mode),
        .PERIOD  (period),
        .PRESCALE(prescale),
        .Q       (q),
        .BUSY    (busy),
        .TC      (tc),
        .DONE    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        mQ = '0; mBusy = 1'b0; mTc = 1'b0; mDone = 1'b0;
        n = 0; lPer = 0; lPre = 0; lMode = 1'b0;
    endtask

    // Advance one clock edge and update the model from the inputs sampled there.
    task automatic step();
        longint len;
        @(posedge clk);
        mTc = 1'b0;
        if (mBusy) begin
            if (stop) begin
                mBusy = 1'b0; n = 0; mQ = '0;
            end else begin
                n++;
                len = longint'(lPer + 1) * longint'(lPre + 1);
                if (n % len == 0) begin
                    mTc = 1'b1;
                    if (!lMode) begin
                        mBusy = 1'b0; mDone = 1'b1; mQ = 8'(lPer);
                    end else begin
                        mQ = '0;
                    end
                end else begin
                    mQ = 8'((n / (lPre + 1)) % (lPer + 1));
                end
            end
        end else if (start && !stop) begin
            lPer = int'(period); lPre = int'(prescale); lMode = mode;
            mBusy = 1'b1; mDone = 1'b0; n = 0; mQ = '0;
        end else if (stop && mDone) begin
            mDone = 1'b0; mQ = '0;
        end
        #1;
    endtask

    task automatic idleInputs();
        start = 1'b0; stop = 1'b0; mode = 1'b0; period = '0; prescale = '0;
    endtask

    task automatic test_reset();
        idleInputs();
        rst_n = 1'b0;
        modelReset();
        #1;
        checks++;
        if ({q, busy, tc, done} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_initial: got q=%0d busy=%b tc=%b done=%b, want all zero", q, busy, tc, done);
        end
        #8 rst_n = 1'b1;
        step();
        start = 1'b1; mode = 1'b0; period = 8'd10; prescale = 4'd0;
        step();
        start = 1'b0;
        repeat (5) step();
        checks++;
        if (q !== 8'd5 || q !== mQ) begin
            errors++;
            $display("[TB] FAIL reset_premid_q: got q=%0d, want 5", q);
        end
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checks++;
        if ({q, busy, tc, done} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_async: got q=%0d busy=%b tc=%b done=%b, want all zero", q, busy, tc, done);
        end
        #2 rst_n = 1'b1;
        repeat (2) step();
        checks++;
        if ({q, busy, tc, done} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_stays_idle: got q=%0d busy=%b, want idle", q, busy);
        end
        start = 1'b1; period = 8'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({q, busy, tc, done} !== {mQ, mBusy, mTc, mDone}) begin
                errors++;
                $display("[TB] FAIL reset_restart cyc%0d: got q=%0d b=%b tc=%b d=%b, want q=%0d b=%b tc=%b d=%b",
                         i, q, busy, tc, done, mQ, mBusy, mTc, mDone);
            end
        end
    endtask

    task automatic test_oneshot();
        stop = 1'b1;
        step();
        idleInputs();
        start = 1'b1; mode = 1'b0; period = 8'd3; prescale = 4'd0;
        step();
        idleInputs();
        checks++;
        if ({q, busy, tc, done} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL oneshot_entry: got q=%0d busy=%b, want q=0 busy=1", q, busy);
        end
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if ({q, busy, tc, done} !== {mQ, mBusy, mTc, mDone}) begin
                errors++;
                $display("[TB] FAIL oneshot cyc%0d: got q=%0d b=%b tc=%b d=%b, want q=%0d b=%b tc=%b d=%b",
                         i, q, busy, tc, done, mQ, mBusy, mTc, mDone);
            end
            if (i == 4) begin
                checks++;
                if ({q, busy, tc, done} !== {8'd3, 1'b0, 1'b1, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL oneshot_tc_at_4: got q=%0d b=%b tc=%b d=%b, want q=3 b=0 tc=1 d=1",
                             q, busy, tc, done);
                end
            end
        end
    endtask

    task automatic test_periodic();
        int tcCount;
        int lastTc;
        tcCount = 0; lastTc = 0;
        stop = 1'b1;
        step();
        idleInputs();
        start = 1'b1; mode = 1'b1; period = 8'd2; prescale = 4'd2;
        step();
        idleInputs();
        for (int i = 1; i <= 28; i++) begin
            step();
            checks++;
            if ({q, busy, tc, done} !== {mQ, mBusy, mTc, mDone}) begin
                errors++;
                $display("[TB] FAIL periodic cyc%0d: got q=%0d b=%b tc=%b d=%b, want q=%0d b=%b tc=%b d=%b",
                         i, q, busy, tc, done, mQ, mBusy, mTc, mDone);
            end
            if (tc) begin
                tcCount++;
                checks++;
                if (i - lastTc !== 9) begin
                    errors++;
                    $display("[TB] FAIL periodic_interval: got %0d cycles, want 9", i - lastTc);
                end
                lastTc = i;
            end
        end
        checks++;
        if (tcCount !== 3) begin
            errors++;
            $display("[TB] FAIL periodic_tc_count: got %0d, want 3", tcCount);
        end
    endtask

    task automatic test_stop();
        stop = 1'b1;
        step();
        idleInputs();
        start = 1'b1; mode = 1'b1; period = 8'd9; prescale = 4'd0;
        step();
        idleInputs();
        repeat (4) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({q, busy, tc, done} !== 11'd0 || mBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_over_tick: got q=%0d b=%b tc=%b d=%b, want all zero", q, busy, tc, done);
        end
        start = 1'b1; stop = 1'b1; period = 8'd1;
        step();
        idleInputs();
        repeat (2) step();
        checks++;
        if ({q, busy, tc, done} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL start_stop_together: got q=%0d busy=%b, want idle", q, busy);
        end
    endtask

    task automatic test_boundary();
        int tcCount;
        logic [7:0] prevQ;
        stop = 1'b1;
        step();
        idleInputs();
        start = 1'b1; mode = 1'b1; period = 8'd0; prescale = 4'd1;
        step();
        idleInputs();
        tcCount = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (tc) tcCount++;
            checks++;
            if ({q, busy, tc, done} !== {mQ, mBusy, mTc, mDone}) begin
                errors++;
                $display("[TB] FAIL period0 cyc%0d: got q=%0d tc=%b, want q=%0d tc=%b", i, q, tc, mQ, mTc);
            end
        end
        checks++;
        if (tcCount !== 5) begin
            errors++;
            $display("[TB] FAIL period0_tc_count: got %0d, want 5", tcCount);
        end
        stop = 1'b1;
        step();
        idleInputs();
        start = 1'b1; mode = 1'b1; period = 8'd255; prescale = 4'd0;
        step();
        idleInputs();
        tcCount = 0; prevQ = q;
        for (int i = 1; i <= 520; i++) begin
            step();
            if (tc) tcCount++;
            if ({q, busy, tc, done} !== {mQ, mBusy, mTc, mDone}) begin
                checks++;
                errors++;
                $display("[TB] FAIL period255 cyc%0d: got q=%0d tc=%b, want q=%0d tc=%b", i, q, tc, mQ, mTc);
            end
            if (prevQ == 8'd255) begin
                checks++;
                if (q !== 8'd0 || tc !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL period255_wrap cyc%0d: got q=%0d tc=%b, want q=0 tc=1", i, q, tc);
                end
            end
            prevQ = q;
        end
        checks++;
        if (tcCount !== 2) begin
            errors++;
            $display("[TB] FAIL period255_tc_count: got %0d, want 2", tcCount);
        end
    endtask

    task automatic test_start_in_run();
        int tcCount;
        stop = 1'b1;
        step();
        idleInputs();
        start = 1'b1; mode = 1'b1; period = 8'd3; prescale = 4'd1;
        step();
        idleInputs();
        tcCount = 0;
        for (int i = 1; i <= 24; i++) begin
            start = (i % 5 == 2);
            period = 8'd7; prescale = 4'd3; mode = 1'b0;
            step();
            if (tc) tcCount++;
            checks++;
            if ({q, busy, tc, done} !== {mQ, mBusy, mTc, mDone}) begin
                errors++;
                $display("[TB] FAIL start_in_run cyc%0d: got q=%0d b=%b tc=%b, want q=%0d b=%b tc=%b",
                         i, q, busy, tc, mQ, mBusy, mTc);
            end
        end
        idleInputs();
        checks++;
        if (tcCount !== 3) begin
            errors++;
            $display("[TB] FAIL start_in_run_tc_count: got %0d, want 3", tcCount);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            start    = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 19) == 0);
            mode     = 1'($urandom_range(0, 1));
            period   = 8'($urandom_range(0, 6));
            prescale = 4'($urandom_range(0, 3));
            step();
            checks++;
            if ({q, busy, tc, done} !== {mQ, mBusy, mTc, mDone}) begin
                errors++;
                $display("[TB] FAIL random cyc%0d: got q=%0d b=%b tc=%b d=%b, want q=%0d b=%b tc=%b d=%b",
                         i, q, busy, tc, done, mQ, mBusy, mTc, mDone);
            end
        end
        idleInputs();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_stop();
        test_boundary();
        test_start_in_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
